// File: rtl/simmem_rrsv_if.sv
// Handshake bundle between the read-reservation initiator and its requester,
// reservation bank, memory controller and delay calculator.
interface simmem_rrsv_if #(
    parameter int unsigned NumIds         = 4,
    parameter int unsigned IdW            = 2,
    parameter int unsigned AddrW          = 32,
    parameter int unsigned LenW           = 8,
    parameter int unsigned IidW           = 6,
    parameter int unsigned MaxOutstanding = 16
);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    logic              ar_valid_i;
    logic              ar_ready_o;
    logic [IdW-1:0]    ar_id_i;
    logic [AddrW-1:0]  ar_addr_i;
    logic [LenW-1:0]   ar_len_i;
    logic [NumIds-1:0] rsv_req_id_onehot_o;
    logic [LenW:0]     rsv_burst_len_o;
    logic              rsv_valid_o;
    logic              rsv_ready_i;
    logic [IidW-1:0]   rsv_iid_i;
    logic              mem_ar_valid_o;
    logic              mem_ar_ready_i;
    logic [IdW-1:0]    mem_ar_id_o;
    logic [AddrW-1:0]  mem_ar_addr_o;
    logic [LenW-1:0]   mem_ar_len_o;
    logic              dc_valid_o;
    logic              dc_ready_i;
    logic [IidW-1:0]   dc_iid_o;
    logic [LenW:0]     dc_burst_len_o;
    logic              burst_done_i;
    logic [OutW-1:0]   outstanding_o;

    modport slave (
        input  ar_valid_i, ar_id_i, ar_addr_i, ar_len_i,
        input  rsv_ready_i, rsv_iid_i, mem_ar_ready_i, dc_ready_i, burst_done_i,
        output ar_ready_o, rsv_req_id_onehot_o, rsv_burst_len_o, rsv_valid_o,
        output mem_ar_valid_o, mem_ar_id_o, mem_ar_addr_o, mem_ar_len_o,
        output dc_valid_o, dc_iid_o, dc_burst_len_o, outstanding_o
    );

    modport master (
        output ar_valid_i, ar_id_i, ar_addr_i, ar_len_i,
        output rsv_ready_i, rsv_iid_i, mem_ar_ready_i, dc_ready_i, burst_done_i,
        input  ar_ready_o, rsv_req_id_onehot_o, rsv_burst_len_o, rsv_valid_o,
        input  mem_ar_valid_o, mem_ar_id_o, mem_ar_addr_o, mem_ar_len_o,
        input  dc_valid_o, dc_iid_o, dc_burst_len_o, outstanding_o
    );
endinterface

// File: rtl/simmem_rrsv_initiator.sv
// Read-reservation initiator: reserves a bank iid per AR burst, then forwards to memory and delay calculator.
// Optional macro SIMMEM_RRSV_ERR_EN adds a sticky err_underflow_o output.
module simmem_rrsv_initiator #(
    parameter int unsigned NumIds         = 4,
    parameter int unsigned IdW            = 2,
    parameter int unsigned AddrW          = 32,
    parameter int unsigned LenW           = 8,
    parameter int unsigned IidW           = 6,
    parameter int unsigned MaxOutstanding = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    simmem_rrsv_if.slave   bus
`ifdef SIMMEM_RRSV_ERR_EN
    ,
    output logic           err_underflow_o
`endif
);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

    typedef enum logic [1:0] {IDLE = 2'd0, RSV = 2'd1, FWD = 2'd2} state_e;

    state_e            state_r;
    logic              ar_ready_r;
    logic              rsv_valid_r;
    logic              mem_valid_r;
    logic              dc_valid_r;
    logic              mem_done_r;
    logic              dc_done_r;
    logic [IdW-1:0]    id_r;
    logic [AddrW-1:0]  addr_r;
    logic [LenW-1:0]   len_r;
    logic [LenW:0]     burst_len_r;
    logic [NumIds-1:0] onehot_r;
    logic [IidW-1:0]   iid_r;
    logic [OutW-1:0]   outstanding_r;

    logic              ar_hs_s;
    logic              rsv_hs_s;
    logic              mem_hs_s;
    logic              dc_hs_s;
    logic              dec_s;
    logic              fwd_last_s;
    logic              ar_ready_n_s;
    logic [OutW-1:0]   out_n_s;

    // Handshakes, next outstanding count and FWD completion.
    always_comb begin
        ar_hs_s  = bus.ar_valid_i && ar_ready_r;
        rsv_hs_s = rsv_valid_r && bus.rsv_ready_i;
        mem_hs_s = mem_valid_r && bus.mem_ar_ready_i;
        dc_hs_s  = dc_valid_r && bus.dc_ready_i;
        // A release at zero only counts when it pairs with a same-cycle reservation.
        dec_s    = bus.burst_done_i && ((outstanding_r != {OutW{1'b0}}) || rsv_hs_s);
        out_n_s  = outstanding_r;
        if (rsv_hs_s && !dec_s) begin
            out_n_s = outstanding_r + {{(OutW-1){1'b0}}, 1'b1};
        end else if (!rsv_hs_s && dec_s) begin
            out_n_s = outstanding_r - {{(OutW-1){1'b0}}, 1'b1};
        end else begin
            out_n_s = outstanding_r;
        end
        fwd_last_s   = (mem_done_r || mem_hs_s) && (dc_done_r || dc_hs_s);
        ar_ready_n_s = (out_n_s < MaxOut);
    end

    // Control FSM with all registered outputs and latched request payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= IDLE;
            ar_ready_r    <= 1'b1;
            rsv_valid_r   <= 1'b0;
            mem_valid_r   <= 1'b0;
            dc_valid_r    <= 1'b0;
            mem_done_r    <= 1'b0;
            dc_done_r     <= 1'b0;
            id_r          <= {IdW{1'b0}};
            addr_r        <= {AddrW{1'b0}};
            len_r         <= {LenW{1'b0}};
            burst_len_r   <= {(LenW+1){1'b0}};
            onehot_r      <= {NumIds{1'b0}};
            iid_r         <= {IidW{1'b0}};
            outstanding_r <= {OutW{1'b0}};
        end else begin
            outstanding_r <= out_n_s;
            case (state_r)
                IDLE: begin
                    if (ar_hs_s) begin
                        id_r        <= bus.ar_id_i;
                        addr_r      <= bus.ar_addr_i;
                        len_r       <= bus.ar_len_i;
                        burst_len_r <= {1'b0, bus.ar_len_i} + {{LenW{1'b0}}, 1'b1};
                        onehot_r    <= {{(NumIds-1){1'b0}}, 1'b1} << bus.ar_id_i;
                        rsv_valid_r <= 1'b1;
                        ar_ready_r  <= 1'b0;
                        state_r     <= RSV;
                    end else begin
                        ar_ready_r  <= ar_ready_n_s;
                    end
                end
                RSV: begin
                    ar_ready_r <= 1'b0;
                    if (rsv_hs_s) begin
                        iid_r       <= bus.rsv_iid_i;
                        rsv_valid_r <= 1'b0;
                        mem_valid_r <= 1'b1;
                        dc_valid_r  <= 1'b1;
                        mem_done_r  <= 1'b0;
                        dc_done_r   <= 1'b0;
                        state_r     <= FWD;
                    end
                end
                FWD: begin
                    if (mem_hs_s) begin
                        mem_valid_r <= 1'b0;
                        mem_done_r  <= 1'b1;
                    end
                    if (dc_hs_s) begin
                        dc_valid_r <= 1'b0;
                        dc_done_r  <= 1'b1;
                    end
                    if (fwd_last_s) begin
                        ar_ready_r <= ar_ready_n_s;
                        state_r    <= IDLE;
                    end else begin
                        ar_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsv_valid_r <= 1'b0;
                    mem_valid_r <= 1'b0;
                    dc_valid_r  <= 1'b0;
                    ar_ready_r  <= ar_ready_n_s;
                end
            endcase
        end
    end

`ifdef SIMMEM_RRSV_ERR_EN
    logic underflow_s;
    logic err_r;

    // Release with nothing outstanding and no pairing reservation.
    always_comb begin
        underflow_s = bus.burst_done_i && (outstanding_r == {OutW{1'b0}}) && !rsv_hs_s;
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r || underflow_s;
        end
    end

    assign err_underflow_o = err_r;
`endif

    assign bus.ar_ready_o          = ar_ready_r;
    assign bus.rsv_valid_o         = rsv_valid_r;
    assign bus.rsv_req_id_onehot_o = onehot_r;
    assign bus.rsv_burst_len_o     = burst_len_r;
    assign bus.mem_ar_valid_o      = mem_valid_r;
    assign bus.mem_ar_id_o         = id_r;
    assign bus.mem_ar_addr_o       = addr_r;
    assign bus.mem_ar_len_o        = len_r;
    assign bus.dc_valid_o          = dc_valid_r;
    assign bus.dc_iid_o            = iid_r;
    assign bus.dc_burst_len_o      = burst_len_r;
    assign bus.outstanding_o       = outstanding_r;
endmodule

// File: tb/tb_simmem_rrsv_initiator.sv
// Scoreboard bench for simmem_rrsv_initiator: directed requests, backpressure, full, overlap, max len, reset.
module tb_simmem_rrsv_initiator;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    simmem_rrsv_if #(.NumIds(4), .IdW(2), .AddrW(32), .LenW(8), .IidW(6), .MaxOutstanding(16)) bus ();

`ifdef SIMMEM_RRSV_ERR_EN
    logic err_underflow_o;
`endif

    simmem_rrsv_initiator #(.NumIds(4), .IdW(2), .AddrW(32), .LenW(8), .IidW(6), .MaxOutstanding(16)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
`ifdef SIMMEM_RRSV_ERR_EN
        ,
        .err_underflow_o (err_underflow_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [12:0] exp_rsv_q[$];   // {onehot, burst_len}
    logic [41:0] exp_mem_q[$];   // {id, addr, len}
    logic [14:0] exp_dc_q[$];    // {iid, burst_len}
    time mem_hs_t = 0;
    time dc_hs_t  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compare every handshake payload against the expected queue head.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus.rsv_valid_o && bus.rsv_ready_i) begin
                if (exp_rsv_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsv_unexpected: got %0h expected none", {bus.rsv_req_id_onehot_o, bus.rsv_burst_len_o});
                end else check("rsv_payload", {51'd0, bus.rsv_req_id_onehot_o, bus.rsv_burst_len_o}, {51'd0, exp_rsv_q.pop_front()});
            end
            if (bus.mem_ar_valid_o && bus.mem_ar_ready_i) begin
                mem_hs_t = $time;
                if (exp_mem_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL mem_unexpected: got %0h expected none", {bus.mem_ar_id_o, bus.mem_ar_addr_o, bus.mem_ar_len_o});
                end else check("mem_payload", {22'd0, bus.mem_ar_id_o, bus.mem_ar_addr_o, bus.mem_ar_len_o}, {22'd0, exp_mem_q.pop_front()});
            end
            if (bus.dc_valid_o && bus.dc_ready_i) begin
                dc_hs_t = $time;
                if (exp_dc_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL dc_unexpected: got %0h expected none", {bus.dc_iid_o, bus.dc_burst_len_o});
                end else check("dc_payload", {49'd0, bus.dc_iid_o, bus.dc_burst_len_o}, {49'd0, exp_dc_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_done(input int n);
        for (int i = 0; i < n; i++) begin
            bus.burst_done_i = 1'b1;
            tick();
        end
        bus.burst_done_i = 1'b0;
    endtask

    task automatic issue(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [5:0] iid);
        bit ok;
        ok = 1'b0;
        bus.ar_id_i    = id;
        bus.ar_addr_i  = addr;
        bus.ar_len_i   = len;
        bus.rsv_iid_i  = iid;
        bus.ar_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (bus.ar_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.ar_valid_i = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL ar_accept_timeout: got ar_ready 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [5:0] iid,
                            input logic [3:0] eoh, input logic [8:0] eblen);
        exp_rsv_q.push_back({eoh, eblen});
        exp_mem_q.push_back({id, addr, len});
        exp_dc_q.push_back({iid, eblen});
    endtask

    task automatic send(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [5:0] iid,
                        input logic [3:0] eoh, input logic [8:0] eblen);
        push_exp(id, addr, len, iid, eoh, eblen);
        issue(id, addr, len, iid);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            #2;
            if (exp_rsv_q.size() == 0 && exp_mem_q.size() == 0 && exp_dc_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        if (!ok) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_rsv_q.size() + exp_mem_q.size() + exp_dc_q.size());
        end
    endtask

    initial begin
        logic [3:0] oh;
        bus.ar_valid_i = 1'b0; bus.ar_id_i = 2'd0; bus.ar_addr_i = 32'd0; bus.ar_len_i = 8'd0;
        bus.rsv_ready_i = 1'b0; bus.rsv_iid_i = 6'd0; bus.mem_ar_ready_i = 1'b0;
        bus.dc_ready_i = 1'b0; bus.burst_done_i = 1'b0;

        // Reset state
        #1 rst_ni = 1'b0;
        #2;
        check("rst_ar_ready", {63'd0, bus.ar_ready_o}, 64'd1);
        check("rst_valids", {61'd0, bus.rsv_valid_o, bus.mem_ar_valid_o, bus.dc_valid_o}, 64'd0);
        check("rst_outstanding", {59'd0, bus.outstanding_o}, 64'd0);
        check("rst_data", {18'd0, bus.rsv_req_id_onehot_o, bus.rsv_burst_len_o, bus.mem_ar_addr_o, bus.dc_iid_o}, 64'd0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // Single request, all readies high
        bus.rsv_ready_i = 1'b1; bus.mem_ar_ready_i = 1'b1; bus.dc_ready_i = 1'b1;
        send(2'd2, 32'h1000, 8'd3, 6'd5, 4'b0100, 9'd4);
        drain();
        check("single_same_cycle", {63'd0, mem_hs_t == dc_hs_t}, 64'd1);
        check("single_outstanding", {59'd0, bus.outstanding_o}, 64'd1);
        check("single_ar_ready", {63'd0, bus.ar_ready_o}, 64'd1);

        // Backpressure on rsv then on mem
        bus.rsv_ready_i = 1'b0; bus.mem_ar_ready_i = 1'b0; bus.dc_ready_i = 1'b1;
        push_exp(2'd1, 32'h2000, 8'd7, 6'd9, 4'b0010, 9'd8);
        issue(2'd1, 32'h2000, 8'd7, 6'd9);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsv_hold", {50'd0, bus.rsv_valid_o, bus.rsv_req_id_onehot_o, bus.rsv_burst_len_o}, {50'd0, 1'b1, 4'b0010, 9'd8});
            tick();
        end
        check("bp_rsv_hold6", {50'd0, bus.rsv_valid_o, bus.rsv_req_id_onehot_o, bus.rsv_burst_len_o}, {50'd0, 1'b1, 4'b0010, 9'd8});
        bus.rsv_ready_i = 1'b1;
        tick();
        bus.rsv_ready_i = 1'b0;
        check("bp_fwd_entry", {61'd0, bus.rsv_valid_o, bus.mem_ar_valid_o, bus.dc_valid_o}, 64'd3);
        tick();
        check("bp_dc_drop", {61'd0, bus.ar_ready_o, bus.mem_ar_valid_o, bus.dc_valid_o}, 64'd2);
        tick();
        check("bp_mem_hold2", {62'd0, bus.ar_ready_o, bus.mem_ar_valid_o}, 64'd1);
        tick();
        check("bp_mem_hold3", {62'd0, bus.ar_ready_o, bus.mem_ar_valid_o}, 64'd1);
        bus.mem_ar_ready_i = 1'b1;
        tick();
        check("bp_idle", {62'd0, bus.ar_ready_o, bus.mem_ar_valid_o}, 64'd2);
        check("bp_outstanding", {59'd0, bus.outstanding_o}, 64'd2);
        bus.rsv_ready_i = 1'b1; bus.dc_ready_i = 1'b1;
        drain();

        // Fill to MaxOutstanding
        for (int i = 0; i < 14; i++) begin
            oh = 4'b0001 << (i % 4);
            send(2'(i % 4), 32'h4000 + 32'(i * 16), 8'(i), 6'(i + 10), oh, 9'(i + 1));
            drain();
        end
        check("full_outstanding", {59'd0, bus.outstanding_o}, 64'd16);
        check("full_ar_ready", {63'd0, bus.ar_ready_o}, 64'd0);
        tick();
        check("full_ar_ready_hold", {63'd0, bus.ar_ready_o}, 64'd0);
        pulse_done(1);
        check("full_release_out", {59'd0, bus.outstanding_o}, 64'd15);
        check("full_release_ready", {63'd0, bus.ar_ready_o}, 64'd1);

        // Release and reserve in the same cycle at 7
        pulse_done(8);
        check("sim_pre_out", {59'd0, bus.outstanding_o}, 64'd7);
        bus.rsv_ready_i = 1'b0;
        push_exp(2'd0, 32'h7000, 8'd0, 6'd33, 4'b0001, 9'd1);
        issue(2'd0, 32'h7000, 8'd0, 6'd33);
        bus.rsv_ready_i = 1'b1;
        bus.burst_done_i = 1'b1;
        tick();
        bus.burst_done_i = 1'b0;
        check("sim_out", {59'd0, bus.outstanding_o}, 64'd7);
        drain();
        check("sim_post_out", {59'd0, bus.outstanding_o}, 64'd7);

        // Maximum len
        send(2'd3, 32'hFFFF_FFF0, 8'hFF, 6'd63, 4'b1000, 9'h100);
        drain();
        check("maxlen_out", {59'd0, bus.outstanding_o}, 64'd8);

        // Underflow at zero
        pulse_done(8);
        check("uf_pre_out", {59'd0, bus.outstanding_o}, 64'd0);
        pulse_done(1);
        check("uf_out", {59'd0, bus.outstanding_o}, 64'd0);
`ifdef SIMMEM_RRSV_ERR_EN
        check("uf_err", {63'd0, err_underflow_o}, 64'd1);
`endif

        // Reset while in FWD
        bus.mem_ar_ready_i = 1'b0; bus.dc_ready_i = 1'b0; bus.rsv_ready_i = 1'b1;
        exp_rsv_q.push_back({4'b0100, 9'd2});
        issue(2'd2, 32'h8000, 8'd1, 6'd7);
        tick();
        check("rst_pre_fwd", {62'd0, bus.mem_ar_valid_o, bus.dc_valid_o}, 64'd3);
        rst_ni = 1'b0;
        #1;
        check("rstfwd_valids", {61'd0, bus.rsv_valid_o, bus.mem_ar_valid_o, bus.dc_valid_o}, 64'd0);
        check("rstfwd_out", {59'd0, bus.outstanding_o}, 64'd0);
        check("rstfwd_ar_ready", {63'd0, bus.ar_ready_o}, 64'd1);
`ifdef SIMMEM_RRSV_ERR_EN
        check("rstfwd_err", {63'd0, err_underflow_o}, 64'd0);
`endif
        tick();
        rst_ni = 1'b1;
        tick();
        check("sb_empty", 64'(exp_rsv_q.size() + exp_mem_q.size() + exp_dc_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
